adc_ser_master: RTL and testbench

//  FPGA-side initiator for one serial ADC channel of sig_acq (pins cs/int/sclk/fs/sdo/sdi/cstart).
//  It pulses cstart, waits for the ADC end-of-conversion (int low), then runs one framed transfer.
//  The transfer shifts a 16-bit command out on sdo and a 14-bit sample in on sdi, MSB first.

---
 rtl/adc_ser_master_pkg.sv | 31 +++
 rtl/adc_ser_master_sclk_gen.sv | 47 ++++
 rtl/adc_ser_master.sv | 181 ++++++++++++++++++
 tb/tb_adc_ser_master.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ser_master_pkg.sv
// rtl/adc_ser_master_pkg.sv - shared FSM encoding and default timing constants for the ADC serial masters
// Contents:
//   state_t        FSM state encoding (IDLE, CSTART, WAIT_HI, WAIT_LO, FRAME, END)
//   *_DEF          default SCLK_DIV / CSTART_W / TIMEOUT / DW / FRAME_BITS shared by ADC0..2
//   CMD_W          width of the command word shifted out on sdo
//   is_wait()      true for the two end-of-conversion wait states
package adc_ser_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CSTART  = 3'd1,
      ST_WAIT_HI = 3'd2,
      ST_WAIT_LO = 3'd3,
      ST_FRAME   = 3'd4,
      ST_END     = 3'd5
   } state_t;

   localparam int SCLK_DIV_DEF   = 4;
   localparam int CSTART_W_DEF   = 8;
   localparam int TIMEOUT_DEF    = 4096;
   localparam int DW_DEF         = 14;
   localparam int FRAME_BITS_DEF = 16;
   localparam int CMD_W          = 16;

   // The timeout window spans both wait states, so the shared counter must
   // survive the WAIT_HI -> WAIT_LO hop.
   function automatic logic is_wait(input state_t s);
      return (s == ST_WAIT_HI) || (s == ST_WAIT_LO);
   endfunction

endpackage

// File: rtl/adc_ser_master_sclk_gen.sv
// rtl/adc_ser_master_sclk_gen.sv - sclk generator with half-period counter and edge strobes
// Ports:
//   clk_in     in   system clock
//   rst_board  in   asynchronous active-low reset
//   en         in   run the generator; low clears the counter and parks sclk low
//   sclk       out  serial clock register, idles low
//   rise       out  strobe in the cycle whose closing clk_in edge raises sclk
//   fall       out  strobe in the cycle whose closing clk_in edge lowers sclk
module adc_ser_master_sclk_gen
   import adc_ser_master_pkg::*;
#(
   parameter int SCLK_DIV = SCLK_DIV_DEF
) (
   input  logic clk_in,
   input  logic rst_board,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int HC_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(SCLK_DIV - 1);

   logic [HC_W-1:0] hc;
   logic            wrap;

   assign wrap = en && (hc == HC_LAST);
   assign rise = wrap && !sclk;
   assign fall = wrap && sclk;

   always_ff @(posedge clk_in or negedge rst_board) begin
      if (!rst_board) begin
         hc   <= '0;
         sclk <= 1'b0;
      end else if (!en) begin
         hc   <= '0;
         sclk <= 1'b0;
      end else if (wrap) begin
         hc   <= '0;
         sclk <= ~sclk;
      end else begin
         hc <= hc + 1'b1;
      end
   end

endmodule

// File: rtl/adc_ser_master.sv
// rtl/adc_ser_master.sv - serial ADC initiator: cstart pulse, EOC wait, one framed cmd/sample transfer
// Ports:
//   clk_in     in   system clock
//   rst_board  in   asynchronous active-low reset
//   start      in   1-cycle conversion request, ignored while busy
//   cmd        in   16-bit command, latched on accepted start
//   cs         out  ADC chip select, active low
//   cstart     out  conversion start, active low
//   int_n      in   ADC end-of-conversion, active low, asynchronous
//   sclk       out  serial clock, idles low
//   fs         out  frame sync, active high
//   sdo        out  command data to ADC
//   sdi        in   sample data from ADC, changes after sclk rise
//   data       out  last captured sample
//   data_vld   out  1-cycle pulse when data updates
//   busy       out  high from accepted start until back in IDLE
//   timeout    out  1-cycle pulse when the EOC wait aborts
module adc_ser_master
   import adc_ser_master_pkg::*;
#(
   parameter int SCLK_DIV   = SCLK_DIV_DEF,
   parameter int CSTART_W   = CSTART_W_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF,
   parameter int DW         = DW_DEF,
   parameter int FRAME_BITS = FRAME_BITS_DEF
) (
   input  logic             clk_in,
   input  logic             rst_board,
   input  logic             start,
   input  logic [CMD_W-1:0] cmd,
   output logic             cs,
   output logic             cstart,
   input  logic             int_n,
   output logic             sclk,
   output logic             fs,
   output logic             sdo,
   input  logic             sdi,
   output logic [DW-1:0]    data,
   output logic             data_vld,
   output logic             busy,
   output logic             timeout
);

   localparam int CNT_MAX = (TIMEOUT > CSTART_W) ?
                            ((TIMEOUT > SCLK_DIV) ? TIMEOUT : SCLK_DIV) :
                            ((CSTART_W > SCLK_DIV) ? CSTART_W : SCLK_DIV);
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam int BIT_W   = $clog2(FRAME_BITS + 1);

   localparam logic [CNT_W-1:0] CSTART_LAST = CNT_W'(CSTART_W - 1);
   localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(SCLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(FRAME_BITS - 1);
   localparam logic [BIT_W-1:0] SDO_LAST    = BIT_W'(CMD_W - 1);
   localparam logic [BIT_W-1:0] DW_BITS     = BIT_W'(DW);

   state_t           state, state_nxt;
   logic             int_s1, int_s2;
   logic [CNT_W-1:0] cnt;
   logic [CMD_W-1:0] cmd_sr;
   logic [DW-1:0]    shift;
   logic [BIT_W-1:0] fall_cnt;
   logic             frame_run;
   logic             sclk_en, sclk_rise, sclk_fall;
   logic             last_fall;
   logic             cs_nxt, cstart_nxt, busy_nxt;

   // One setup cycle after FRAME entry before hc starts, giving the
   // 1 + 2*FRAME_BITS*SCLK_DIV frame body.
   assign sclk_en   = (state == ST_FRAME) && frame_run;
   assign last_fall = sclk_fall && (fall_cnt == BIT_LAST);

   adc_ser_master_sclk_gen #(
      .SCLK_DIV (SCLK_DIV)
   ) u_sclk_gen (
      .clk_in    (clk_in),
      .rst_board (rst_board),
      .en        (sclk_en),
      .sclk      (sclk),
      .rise      (sclk_rise),
      .fall      (sclk_fall)
   );

   always_ff @(posedge clk_in or negedge rst_board) begin
      if (!rst_board) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (start) state_nxt = ST_CSTART;
         ST_CSTART:  if (cnt == CSTART_LAST) state_nxt = ST_WAIT_HI;
         ST_WAIT_HI: begin
            if (int_s2)                state_nxt = ST_WAIT_LO;
            else if (cnt == TMO_LAST)  state_nxt = ST_IDLE;
         end
         ST_WAIT_LO: begin
            if (!int_s2)               state_nxt = ST_FRAME;
            else if (cnt == TMO_LAST)  state_nxt = ST_IDLE;
         end
         ST_FRAME:   if (last_fall) state_nxt = ST_END;
         ST_END:     if (cnt == HALF_LAST) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Decoded from the next state and registered below so the pins never glitch.
   always_comb begin
      cs_nxt     = 1'b1;
      cstart_nxt = 1'b1;
      busy_nxt   = 1'b1;
      case (state_nxt)
         ST_IDLE:          busy_nxt   = 1'b0;
         ST_CSTART:        cstart_nxt = 1'b0;
         ST_FRAME, ST_END: cs_nxt     = 1'b0;
         default:          ;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_board) begin
      if (!rst_board) begin
         int_s1    <= 1'b1;
         int_s2    <= 1'b1;
         cnt       <= '0;
         cs        <= 1'b1;
         cstart    <= 1'b1;
         busy      <= 1'b0;
         fs        <= 1'b0;
         sdo       <= 1'b0;
         data      <= '0;
         data_vld  <= 1'b0;
         timeout   <= 1'b0;
         cmd_sr    <= '0;
         shift     <= '0;
         fall_cnt  <= '0;
         frame_run <= 1'b0;
      end else begin
         int_s1    <= int_n;
         int_s2    <= int_s1;
         cs        <= cs_nxt;
         cstart    <= cstart_nxt;
         busy      <= busy_nxt;
         frame_run <= (state == ST_FRAME);
         data_vld  <= (state == ST_END) && (state_nxt == ST_IDLE);
         timeout   <= is_wait(state) && (state_nxt == ST_IDLE);

         if ((state_nxt != state) && !(is_wait(state) && is_wait(state_nxt)))
            cnt <= '0;
         else if (cnt != '1)
            cnt <= cnt + 1'b1;

         if ((state == ST_IDLE) && start)
            cmd_sr <= cmd;

         if ((state != ST_FRAME) && (state_nxt == ST_FRAME)) begin
            fs       <= 1'b1;
            sdo      <= cmd_sr[CMD_W-1];
            fall_cnt <= '0;
         end else if ((state == ST_FRAME) && sclk_fall) begin
            fs <= 1'b0;
            if (fall_cnt < SDO_LAST) begin
               sdo    <= cmd_sr[CMD_W-2];
               cmd_sr <= cmd_sr << 1;
            end
            if (fall_cnt < DW_BITS)
               shift <= {shift[DW-2:0], sdi};
            if (fall_cnt != BIT_LAST)
               fall_cnt <= fall_cnt + 1'b1;
         end else if (state != ST_FRAME) begin
            fall_cnt <= '0;
         end

         if ((state == ST_END) && (state_nxt == ST_IDLE)) begin
            data <= shift;
            sdo  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_adc_ser_master.sv
// tb/tb_adc_ser_master.sv - self-checking bench for adc_ser_master with a behavioural ADC model
module tb_adc_ser_master;

   localparam int CSTART_W  = 8;
   localparam int TIMEOUT   = 4096;
   localparam int FRAME_LEN = 133;
   localparam int NVEC      = 100;

   typedef struct {
      logic [15:0] cmd;
      int          int_dly;
      logic [13:0] exp_data;
   } vec_t;

   logic        clk_in = 1'b0;
   logic        rst_board;
   logic        start = 1'b0;
   logic [15:0] cmd = '0;
   logic        cs, cstart, sclk, fs, sdo;
   logic        int_n = 1'b1;
   logic        sdi = 1'b0;
   logic [13:0] data;
   logic        data_vld, busy, timeout;

   int checks   = 0;
   int failures = 0;

   adc_ser_master dut (
      .clk_in    (clk_in),
      .rst_board (rst_board),
      .start     (start),
      .cmd       (cmd),
      .cs        (cs),
      .cstart    (cstart),
      .int_n     (int_n),
      .sclk      (sclk),
      .fs        (fs),
      .sdo       (sdo),
      .sdi       (sdi),
      .data      (data),
      .data_vld  (data_vld),
      .busy      (busy),
      .timeout   (timeout)
   );

   always #5 clk_in = ~clk_in;

   // ADC model: loads an incrementing value on the fs rise, rotates it MSB first on sdi.
   logic [13:0] adc_cnt  = '0;
   logic [13:0] adc_sh   = '0;
   logic [15:0] rx_cmd   = '0;
   int          rises    = 0;
   int          fs_rises = 0;

   always @(posedge sclk or negedge cs or negedge rst_board) begin
      if (!rst_board) begin
         adc_cnt = '0; adc_sh = '0; sdi = 1'b0;
         rises = 0; fs_rises = 0; rx_cmd = '0;
      end else if (sclk) begin
         rises++;
         rx_cmd = {rx_cmd[14:0], sdo};
         if (fs) begin
            fs_rises++;
            adc_cnt = adc_cnt + 14'd1;
            adc_sh  = adc_cnt;
         end else begin
            adc_sh = {adc_sh[12:0], adc_sh[13]};
         end
         sdi = adc_sh[13];
      end else if (!cs) begin
         rises = 0; fs_rises = 0; rx_cmd = '0;
      end
   end

   // int driver modes: 0 low int_dly cycles after cstart rises (until cs low),
   // 1 held high, 2 held low, 3 low until the frame starts then high.
   int   int_mode = 1;
   int   int_dly  = 0;
   int   int_cd   = -1;
   logic cstart_q = 1'b1;
   bit   cs_seen  = 1'b0;

   always @(negedge clk_in) begin
      case (int_mode)
         0: begin
            if (!cstart_q && cstart) int_cd = int_dly;
            else if (int_cd > 0)     int_cd--;
            else if (int_cd == 0)    begin int_n = 1'b0; int_cd = -1; end
            if (!cs) int_n = 1'b1;
         end
         1: int_n = 1'b1;
         2: int_n = 1'b0;
         default: begin
            if (!cs) cs_seen = 1'b1;
            int_n = cs_seen;
         end
      endcase
      if (int_mode != 3) cs_seen = 1'b0;
      cstart_q = cstart;
   end

   int   dv_count    = 0;
   int   to_count    = 0;
   int   frame_count = 0;
   logic cs_prev     = 1'b1;

   always @(negedge clk_in) begin
      if (data_vld) dv_count++;
      if (timeout)  to_count++;
      if (cs_prev && !cs) frame_count++;
      cs_prev = cs;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic pulse_start(input logic [15:0] c);
      @(negedge clk_in);
      start = 1'b1;
      cmd   = c;
      @(negedge clk_in);
      start = 1'b0;
   endtask

   task automatic run_conv(input string tag, input logic [15:0] c, input int dly,
                           input logic [13:0] exp_d);
      int n, lo, dv0, fr0;
      dv0      = dv_count;
      fr0      = frame_count;
      int_dly  = dly;
      int_mode = 0;
      pulse_start(c);
      chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
      n = 0;
      while (cstart && n < 20) begin @(negedge clk_in); n++; end
      lo = 0;
      while (!cstart && lo < 100) begin @(negedge clk_in); lo++; end
      chk({tag, "_cstart_width"}, 32'(lo), 32'(CSTART_W));
      n = 0;
      while (cs && n < 2000) begin @(negedge clk_in); n++; end
      chk({tag, "_frame_started"}, 32'(cs), 32'd0);
      n = 0;
      while (!data_vld && n < 300) begin @(negedge clk_in); n++; end
      chk({tag, "_frame_len"}, 32'(n), 32'(FRAME_LEN));
      chk({tag, "_data"}, 32'(data), 32'(exp_d));
      chk({tag, "_busy_at_vld"}, 32'(busy), 32'd0);
      chk({tag, "_cs_at_vld"}, 32'(cs), 32'd1);
      chk({tag, "_sdo_bits"}, 32'(rx_cmd), 32'(c));
      chk({tag, "_rises"}, 32'(rises), 32'd16);
      chk({tag, "_fs_rises"}, 32'(fs_rises), 32'd1);
      @(negedge clk_in);
      chk({tag, "_vld_pulse"}, 32'(data_vld), 32'd0);
      chk({tag, "_vld_count"}, 32'(dv_count - dv0), 32'd1);
      chk({tag, "_frame_count"}, 32'(frame_count - fr0), 32'd1);
   endtask

   vec_t tbl [NVEC];

   initial begin
      int n, dv0, fr0, to0;

      for (int i = 0; i < NVEC; i++) begin
         tbl[i].cmd      = 16'(i * 16'h1357) ^ 16'hA5C3;
         tbl[i].int_dly  = (i * 13) % 20;
         tbl[i].exp_data = 14'(i + 1);
      end

      // Reset values
      rst_board = 1'b0;
      repeat (3) @(negedge clk_in);
      chk("rst_cs", 32'(cs), 32'd1);
      chk("rst_cstart", 32'(cstart), 32'd1);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_fs", 32'(fs), 32'd0);
      chk("rst_sdo", 32'(sdo), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_data_vld", 32'(data_vld), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      rst_board = 1'b1;
      repeat (2) @(negedge clk_in);

      // 1: reset in the middle of a frame
      int_mode = 0;
      int_dly  = 10;
      pulse_start(16'h1234);
      n = 0;
      while (cs && n < 2000) begin @(negedge clk_in); n++; end
      chk("t1_frame_started", 32'(cs), 32'd0);
      repeat (40) @(negedge clk_in);
      dv0 = dv_count;
      rst_board = 1'b0;
      #1;
      chk("t1_cs", 32'(cs), 32'd1);
      chk("t1_sclk", 32'(sclk), 32'd0);
      chk("t1_fs", 32'(fs), 32'd0);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_cstart", 32'(cstart), 32'd1);
      repeat (3) @(negedge clk_in);
      rst_board = 1'b1;
      repeat (200) @(negedge clk_in);
      chk("t1_no_vld", 32'(dv_count - dv0), 32'd0);
      chk("t1_data", 32'(data), 32'd0);
      chk("t1_idle_cs", 32'(cs), 32'd1);

      // 2: single conversion with a late EOC
      run_conv("t2", 16'hA5C3, 200, 14'h0001);

      // Board reset restarts the ADC model count
      @(negedge clk_in);
      rst_board = 1'b0;
      repeat (3) @(negedge clk_in);
      rst_board = 1'b1;
      @(negedge clk_in);

      // 3: back-to-back conversions from the vector table
      for (int i = 0; i < NVEC; i++)
         run_conv($sformatf("t3_%0d", i), tbl[i].cmd, tbl[i].int_dly, tbl[i].exp_data);

      // 4: int never falls -> timeout, then a normal conversion
      int_mode = 1;
      fr0 = frame_count;
      to0 = to_count;
      pulse_start(16'h0F0F);
      n = 0;
      while (cstart && n < 20) begin @(negedge clk_in); n++; end
      n = 0;
      while (!cstart && n < 20) begin @(negedge clk_in); n++; end
      n = 0;
      while (!timeout && n < TIMEOUT + 500) begin @(negedge clk_in); n++; end
      chk("t4_timeout_at", 32'(n), 32'(TIMEOUT));
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_cs", 32'(cs), 32'd1);
      @(negedge clk_in);
      chk("t4_timeout_pulse", 32'(timeout), 32'd0);
      chk("t4_timeout_count", 32'(to_count - to0), 32'd1);
      chk("t4_no_frame", 32'(frame_count - fr0), 32'd0);
      run_conv("t4_after", 16'h3C96, 7, 14'd101);

      // 5: stale EOC already low when the conversion starts
      int_mode = 2;
      repeat (5) @(negedge clk_in);
      dv0 = dv_count;
      fr0 = frame_count;
      pulse_start(16'h5AA5);
      n = 0;
      while (!cstart && n < 20) begin @(negedge clk_in); n++; end
      repeat (50) @(negedge clk_in);
      chk("t5_hold_hi_cs", 32'(cs), 32'd1);
      chk("t5_hold_hi_busy", 32'(busy), 32'd1);
      int_mode = 1;
      repeat (20) @(negedge clk_in);
      chk("t5_hold_lo_cs", 32'(cs), 32'd1);
      chk("t5_hold_lo_busy", 32'(busy), 32'd1);
      int_mode = 3;
      n = 0;
      while (!data_vld && n < 400) begin @(negedge clk_in); n++; end
      chk("t5_data", 32'(data), 32'd102);
      chk("t5_sdo_bits", 32'(rx_cmd), 32'h5AA5);
      @(negedge clk_in);
      chk("t5_vld_count", 32'(dv_count - dv0), 32'd1);
      chk("t5_frame_count", 32'(frame_count - fr0), 32'd1);

      // 6: start held every cycle while busy (covers start at END exit)
      int_mode = 0;
      int_dly  = 5;
      dv0 = dv_count;
      fr0 = frame_count;
      @(negedge clk_in);
      start = 1'b1;
      cmd   = 16'hC001;
      n = 0;
      do begin
         @(negedge clk_in);
         n++;
         start = busy;
      end while (busy && n < 2000);
      start = 1'b0;
      chk("t6_data", 32'(data), 32'd103);
      repeat (300) @(negedge clk_in);
      chk("t6_vld_count", 32'(dv_count - dv0), 32'd1);
      chk("t6_frame_count", 32'(frame_count - fr0), 32'd1);
      chk("t6_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
